// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the push-button conditioner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package btn_pkg;

  // Debounce FSM states: stable released, counting towards pressed,
  // stable held, counting towards released.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  // 10 ms and 1 s at a 100 MHz core clock.
  localparam int BTN_DEBOUNCE_CYCLES_DEF = 1_000_000;
  localparam int BTN_LONG_CYCLES_DEF     = 100_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous level input, synchronous reset.
// Latency: 2 clk edges from d to q.
// Backpressure: none (free-running level path).
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  // Shift the pad level through two flops to settle metastability.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop sync, counter-qualified debounce FSM, press/release
// pulses and (with BTN_DEBOUNCE_LONG_PRESS_EN defined) a long-press pulse.
// Latency: DEBOUNCE_CYCLES+2 edges pad-to-level; no backpressure (outputs are free-running).
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES_DEF,
  parameter int LONG_CYCLES     = BTN_LONG_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_0,
  output logic btn_db,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          s2;
  btn_state_t    state;
  btn_state_t    state_nxt;
  logic [CW-1:0] cnt;
  logic          cnt_clr;
  logic          press_nxt;
  logic          release_nxt;
  logic          in_wait;
  logic          run_done;
  int            run_len;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_0),
    .q   (s2)
  );

  assign in_wait = (state == PRESS_WAIT) || (state == RELEASE_WAIT);

  // Length of the current run of s2 at the opposite level, including this edge.
  // The edge that leaves a stable state is the first sample of the run, so a WAIT
  // state has already seen cnt+1 samples and this edge adds one more. This keeps
  // the pad-to-level latency at DEBOUNCE_CYCLES+2 and lets DEBOUNCE_CYCLES=1
  // accept straight from a stable state.
  always_comb begin
    run_len = 1;
    if (in_wait) run_len = int'(cnt) + 2;
  end

  assign run_done = (run_len >= DEBOUNCE_CYCLES);

  // Next-state decode; counter clears on every state change and on bounces.
  always_comb begin
    state_nxt   = state;
    cnt_clr     = 1'b0;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (s2) begin
          cnt_clr = 1'b1;
          if (run_done) begin
            state_nxt = PRESSED;
            press_nxt = 1'b1;
          end else begin
            state_nxt = PRESS_WAIT;
          end
        end
      end
      PRESS_WAIT: begin
        if (!s2) begin
          state_nxt = IDLE;
          cnt_clr   = 1'b1;
        end else if (run_done) begin
          state_nxt = PRESSED;
          press_nxt = 1'b1;
          cnt_clr   = 1'b1;
        end
      end
      PRESSED: begin
        if (!s2) begin
          cnt_clr = 1'b1;
          if (run_done) begin
            state_nxt   = IDLE;
            release_nxt = 1'b1;
          end else begin
            state_nxt = RELEASE_WAIT;
          end
        end
      end
      RELEASE_WAIT: begin
        if (s2) begin
          state_nxt = PRESSED;
          cnt_clr   = 1'b1;
        end else if (run_done) begin
          state_nxt   = IDLE;
          release_nxt = 1'b1;
          cnt_clr     = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_clr   = 1'b1;
      end
    endcase
  end

  // State, saturating stability counter and registered level/event outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      btn_db      <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      state       <= state_nxt;
      btn_db      <= (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);
      btn_press   <= press_nxt;
      btn_release <= release_nxt;
      if (cnt_clr) begin
        cnt <= '0;
      end else if (in_wait && (cnt != CNT_MAX)) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
  localparam int LW = $clog2(LONG_CYCLES + 1);
  localparam logic [LW-1:0] HOLD_MAX = LW'(LONG_CYCLES);

  logic [LW-1:0] hold_cnt;
  logic          long_hit;

  // Fire on the edge the hold count reaches LONG_CYCLES; a release on that same
  // edge wins so the event pulses stay mutually exclusive.
  assign long_hit = btn_db && !release_nxt && (hold_cnt == LW'(LONG_CYCLES - 1));

  // Count cycles held since btn_db rose; saturation gives one pulse per hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
      btn_long <= 1'b0;
    end else begin
      btn_long <= long_hit;
      if (press_nxt || release_nxt || !btn_db) begin
        hold_cnt <= '0;
      end else if (hold_cnt != HOLD_MAX) begin
        hold_cnt <= hold_cnt + LW'(1);
      end
    end
  end
`else
  // Feature compiled out: LONG_CYCLES is always >= 1, so this is constant 0.
  assign btn_long = (LONG_CYCLES < 0);
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_btn_debounce;

  localparam int D = 4;
  localparam int L = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_0 = 1'b0;
  logic btn_db, btn_press, btn_release, btn_long;

  int errors = 0;
  int checks = 0;

  // Reference model: debounced level flips once D consecutive edges have seen the
  // two-edge-delayed pad at the opposite level.
  bit hist[$];
  int n = 0;
  int streak = 0;
  int rise_n = -1;
  bit m_db = 0, m_press = 0, m_rel = 0, m_long = 0;

  typedef struct {
    bit b;
    bit r;
    bit e_db;
    bit e_press;
    bit e_rel;
  } vec_t;

  vec_t tbl[18];

  btn_debounce #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_0       (btn_0),
    .btn_db      (btn_db),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_long    (btn_long)
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_edge(input bit b, input bit r);
    bit s2;
    m_press = 0;
    m_rel   = 0;
    m_long  = 0;
    if (r) begin
      hist.delete();
      n      = 0;
      streak = 0;
      rise_n = -1;
      m_db   = 0;
    end else begin
      s2 = (n >= 2) ? hist[n-2] : 1'b0;
      hist.push_back(b);
      if (s2 != m_db) begin
        streak++;
        if (streak == D) begin
          m_db   = !m_db;
          streak = 0;
          if (m_db) begin
            m_press = 1;
            rise_n  = n;
          end else begin
            m_rel = 1;
          end
        end
      end else begin
        streak = 0;
      end
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
      if (m_db && !m_press && rise_n >= 0 && (n - rise_n) == L) m_long = 1;
`endif
      n++;
    end
  endtask

  // Apply one cycle of input, advance the model and compare all outputs.
  task automatic step(input bit b, input bit r);
    btn_0 = b;
    rst   = r;
    @(posedge clk);
    model_edge(b, r);
    #1;
    check_bit("btn_db", btn_db, m_db);
    check_bit("btn_press", btn_press, m_press);
    check_bit("btn_release", btn_release, m_rel);
    check_bit("btn_long", btn_long, m_long);
  endtask

  initial begin
    int press_cnt, press_at, rel_cnt, low_cnt, long_cnt, long_at, rise_at;
    bit bp[13];

    // Clean press then clean release, expectations straight from the timing rules.
    for (int i = 0; i < 2; i++) tbl[i] = '{0, 1, 0, 0, 0};
    for (int i = 0; i < 8; i++) tbl[2+i]  = '{1, 0, (i >= 5), (i == 5), 0};
    for (int i = 0; i < 8; i++) tbl[10+i] = '{0, 0, (i < 5), 0, (i == 5)};

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].b, tbl[i].r);
      check_bit("tbl_db", btn_db, tbl[i].e_db);
      check_bit("tbl_press", btn_press, tbl[i].e_press);
      check_bit("tbl_release", btn_release, tbl[i].e_rel);
    end

    // Bouncy press: 1,0,1,1,0 then held; press 6 edges after the last 0->1 (edge 11).
    step(0, 1);
    bp = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    press_cnt = 0;
    press_at  = 0;
    for (int i = 0; i < 13; i++) begin
      step(bp[i], 0);
      if (btn_press) begin
        press_cnt++;
        press_at = i + 1;
      end
    end
    check_int("bouncy_press_edge", press_at, 11);
    check_int("bouncy_press_count", press_cnt, 1);

    // Release glitch of 2 cycles while held: level must not drop.
    rel_cnt = 0;
    low_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step((i >= 2), 0);
      if (btn_release) rel_cnt++;
      if (!btn_db) low_cnt++;
    end
    check_int("glitch_release_count", rel_cnt, 0);
    check_int("glitch_db_low_cycles", low_cnt, 0);

    // Reset during PRESS_WAIT with the button still held: fresh press afterwards.
    step(0, 1);
    for (int i = 0; i < 4; i++) step(1, 0);
    step(1, 1);
    check_bit("rst_db", btn_db, 1'b0);
    check_bit("rst_press", btn_press, 1'b0);
    press_at  = 0;
    press_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 0);
      if (btn_press) begin
        press_cnt++;
        press_at = i + 1;
      end
    end
    check_int("rst_repress_edge", press_at, 6);
    check_int("rst_repress_count", press_cnt, 1);

    // Long press: hold 40 cycles after btn_db rises.
    step(0, 1);
    rise_at  = 0;
    long_cnt = 0;
    long_at  = 0;
    for (int i = 1; i <= 46; i++) begin
      step(1, 0);
      if (btn_press) rise_at = i;
      if (btn_long) begin
        long_cnt++;
        long_at = i;
      end
    end
    check_int("long_rise_edge", rise_at, 6);
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
    check_int("long_count", long_cnt, 1);
    check_int("long_delay", long_at - rise_at, L);
`else
    check_int("long_count", long_cnt, 0);
`endif
    for (int i = 0; i < 8; i++) step(0, 0);

    // Randomised runs of random length with occasional resets.
    for (int k = 0; k < 400; k++) begin
      bit lvl;
      int len;
      lvl = 1'($urandom_range(0, 1));
      len = (($urandom_range(0, 3)) == 0) ? $urandom_range(20, 30) : $urandom_range(1, 8);
      for (int j = 0; j < len; j++) begin
        step(lvl, ($urandom_range(0, 99) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Conditions the raw board push-button `btn_0` into a clean, glitch-free level plus single-cycle press/release event pulses. It sits directly upstream of the LED/button logic and replaces the raw pad signal as that logic's input. It synchronises the asynchronous pad into the clock domain and debounces it with a counter-qualified state machine. It optionally detects a long press.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: cycles the input must be stable before a level change is accepted (10 ms at 100 MHz); legal range ≥ 1.
- `LONG_CYCLES`, default 100_000_000: cycles `btn_db` must stay high before `btn_long` fires (1 s at 100 MHz); legal range ≥ 1; used only with the long-press feature.

Ports:
- `clk` input 1: system clock, all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `btn_0` input 1: raw, asynchronous, bouncing button pad, active-high.
- `btn_db` output 1: debounced button level.
- `btn_press` output 1: one-cycle pulse when `btn_db` goes 0→1.
- `btn_release` output 1: one-cycle pulse when `btn_db` goes 1→0.
- `btn_long` output 1: one-cycle pulse when the button has been held `LONG_CYCLES`; tied 0 when the feature is compiled out.

## Operation
- Synchroniser: 2-flop chain `btn_0` → s1 → s2. Only s2 feeds the logic.
- The FSM has four states:
  - IDLE: stable released.
  - PRESS_WAIT: s2 = 1 and stability is being counted.
  - PRESSED: stable held.
  - RELEASE_WAIT: s2 = 0 and stability is being counted.
- Transitions:
  - IDLE → PRESS_WAIT when s2 = 1.
  - PRESS_WAIT → IDLE when s2 = 0 (bounce; counter cleared).
  - PRESS_WAIT → PRESSED when the counter reaches `DEBOUNCE_CYCLES` with s2 still 1. On that transition `btn_db` goes to 1 and `btn_press` pulses.
  - PRESSED ↔ RELEASE_WAIT mirrors the above. Completing RELEASE_WAIT sets `btn_db` to 0 and pulses `btn_release`.
- Stability counter:
  - Width is `$clog2(DEBOUNCE_CYCLES+1)`.
  - Cleared on every state entry and on every bounce.
  - Increments once per cycle in the WAIT states and never wraps.
- `btn_db` is 1 exactly in PRESSED and RELEASE_WAIT. A release bounce does not drop the level.
- `btn_press`, `btn_release` and `btn_long` are registered and mutually exclusive. Each is high for exactly one cycle per event.
- Reset:
  - Clears s1, s2, the counters and all outputs to 0, and sets the state to IDLE.
  - Reset asserted mid-WAIT or mid-PRESSED aborts with no pulse.
  - A button already held when reset deasserts is treated as a fresh press.

## Timing
- Counting the first rising edge that samples `btn_0` = 1 as edge 1: s2 rises after edge 2, then `btn_db` and `btn_press` assert after edge `DEBOUNCE_CYCLES`+2.
- Release latency is identical: `DEBOUNCE_CYCLES`+2 edges.
- A level that reverts before the count completes produces no output change. The next stable level restarts the full count.
- With `DEBOUNCE_CYCLES` = 1, any input level held for 3 consecutive edges is accepted.
- Output pulses are coincident with the `btn_db` edge, on the same cycle.

## Configuration
- Macro `BTN_DEBOUNCE_LONG_PRESS_EN`.
- When defined:
  - A hold counter of width `$clog2(LONG_CYCLES+1)` is cleared when `btn_db` rises.
  - It increments each cycle `btn_db` = 1 and saturates.
  - `btn_long` pulses once, on the cycle the count reaches `LONG_CYCLES`.
  - The counter is cleared when `btn_db` falls.
  - One hold produces at most one `btn_long`.
- When not defined: no hold counter is built and `btn_long` is constant 0. All other behaviour is unchanged.

## Structure
- Package `btn_pkg`:
  - State enum typedef `btn_state_t` {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT}.
  - Default constants `BTN_DEBOUNCE_CYCLES_DEF` and `BTN_LONG_CYCLES_DEF`.
- Sub-module `sync_2ff`: 1-bit two-flop synchroniser with synchronous reset, reusable for other pad inputs.
- `btn_debounce` contains the FSM, the stability counter, the optional hold counter and the registered output pulses.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `LONG_CYCLES`=20.
- Clean press: `btn_0` 0→1 at edge 1 and held → `btn_db`=1 and a single `btn_press` after edge 6. No other pulses.
- Bouncy press: `btn_0` toggles 1,0,1,1,0 on edges 1–5, then holds 1 → no output until 6 edges after the last 0→1. Exactly one `btn_press`.
- Release glitch: while PRESSED, `btn_0`=0 for 2 cycles, then 1 → `btn_db` stays 1 and `btn_release` never fires.
- Clean release: `btn_0` held 0 → `btn_db`=0 and one `btn_release` after edge 6 from the first 0 sample.
- Reset mid-operation:
  - `rst` for 1 cycle during PRESS_WAIT → all outputs 0 with no pulse.
  - If `btn_0` is still held, `btn_press` fires 6 edges after `rst` deasserts.
- Long press (`BTN_DEBOUNCE_LONG_PRESS_EN`):
  - Hold for 40 cycles after `btn_db` rises → a single `btn_long` 20 cycles after `btn_db` rose.
  - Without the macro → `btn_long` stays 0 throughout.
